// File: rtl/sar_search.sv
// Sequential binary-search engine that steers the b operand of a magnitude comparator.
// Optional invalid-comparator-code detection is enabled by defining SAR_SEARCH_ERR_EN.
module sar_search #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] probes,
  output logic             err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PROBE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] lo_q,     lo_d;
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic [WIDTH-1:0] guess_q,  guess_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] probes_q, probes_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             found_q,  found_d;
  logic             end_c;

`ifdef SAR_SEARCH_ERR_EN
  logic             err_q,    err_d;
  logic             bad_code_c;

  // A valid comparator code has exactly one of gt/eq/lt high.
  assign bad_code_c = !((cmp_gt ^ cmp_eq ^ cmp_lt) && !(cmp_gt && cmp_eq && cmp_lt));
`endif

  // Midpoint carried in WIDTH+1 bits so lo+hi cannot wrap.
  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[WIDTH:1];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      guess_q  <= '0;
      result_q <= '0;
      probes_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
`ifdef SAR_SEARCH_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      probes_q <= probes_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
`ifdef SAR_SEARCH_ERR_EN
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    guess_d  = guess_q;
    result_d = result_q;
    probes_d = probes_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    found_d  = found_q;
    end_c    = 1'b0;
`ifdef SAR_SEARCH_ERR_EN
    err_d    = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          lo_d     = '0;
          hi_d     = MAX_VAL;
          guess_d  = MAX_VAL >> 1;
          probes_d = '0;
          found_d  = 1'b0;
          result_d = '0;
          busy_d   = 1'b1;
          state_d  = S_PROBE;
`ifdef SAR_SEARCH_ERR_EN
          err_d    = 1'b0;
`endif
        end
      end

      S_PROBE: begin
        probes_d = probes_q + ONE;
        busy_d   = 1'b1;
        // Decode priority eq > gt > lt; an all-zero code falls through to lt.
`ifdef SAR_SEARCH_ERR_EN
        if (bad_code_c) begin
          err_d   = 1'b1;
          found_d = 1'b0;
          end_c   = 1'b1;
        end else
`endif
        if (cmp_eq) begin
          found_d = 1'b1;
          end_c   = 1'b1;
        end else if (cmp_gt) begin
          if (guess_q == hi_q) begin
            found_d = 1'b0;
            end_c   = 1'b1;
          end else begin
            lo_d    = guess_q + ONE;
            guess_d = midpoint(guess_q + ONE, hi_q);
          end
        end else begin
          if (guess_q == lo_q) begin
            found_d = 1'b0;
            end_c   = 1'b1;
          end else begin
            hi_d    = guess_q - ONE;
            guess_d = midpoint(lo_q, guess_q - ONE);
          end
        end

        if (end_c) begin
          result_d = guess_q;
          guess_d  = guess_q;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign guess  = guess_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign found  = found_q;
  assign result = result_q;
  assign probes = probes_q;
`ifdef SAR_SEARCH_ERR_EN
  assign err    = err_q;
`else
  assign err    = 1'b0;
`endif

endmodule

// File: doc/sar_search.md
# sar_search

Sequential binary-search engine driving the operand side of the team's 4-bit magnitude comparator. It presents a trial value (`guess`) to the comparator and consumes the comparator's greater/equal/less result each cycle. It narrows the range until equality is reported, then returns the located value. It is the consumer counterpart to the comparator: the comparator judges a pair, this block steers the pair.

## Interface
Parameters:
- `WIDTH`, 4, operand width; the search range is 0 to 2^WIDTH-1.

Ports:
- `clk`  input  1  the block's single clock; every register updates on its rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `start`  input  1  request to begin a search; honoured only in IDLE.
- `cmp_gt`  input  1  the unknown target is greater than `guess`.
- `cmp_eq`  input  1  the unknown target equals `guess`.
- `cmp_lt`  input  1  the unknown target is less than `guess`.
- `guess`  output  WIDTH  trial value, registered, fed to the comparator's b operand.
- `busy`  output  1  high while in PROBE.
- `done`  output  1  one-cycle pulse when a search ends.
- `found`  output  1  last search ended on equality; held until next start.
- `result`  output  WIDTH  final `guess` of the last search; held until next start.
- `probes`  output  WIDTH  number of probe cycles used by the last or current search.
- `err`  output  1  invalid comparator code seen; present only with the macro, tied 0 otherwise.

## Operation
- States are IDLE, PROBE and DONE.
- Internal `lo` and `hi` registers are WIDTH bits. The midpoint is `(lo+hi)>>1`, computed in WIDTH+1 bits so there is no overflow.
- IDLE with `start`=1:
  - Set lo=0, hi=2^WIDTH-1, guess=(2^WIDTH-1)>>1, and probes=0.
  - Clear found and result.
  - Go to PROBE.
- PROBE samples the cmp inputs every cycle and increments probes. Decode priority is eq > gt > lt.
  - eq: found=1, result=guess, go to DONE.
  - gt and guess==hi: found=0, result=guess, go to DONE. This is the range-exhausted case.
  - gt otherwise: lo=guess+1, guess=midpoint(guess+1,hi).
  - lt and guess==lo: found=0, result=guess, go to DONE. This is the range-exhausted case; the check avoids underflow.
  - lt otherwise: hi=guess-1, guess=midpoint(lo,guess-1).
  - No cmp input high: treat as lt.
- DONE: done=1 for one cycle, then go to IDLE.
- `start` is ignored in PROBE and DONE; there is no queuing.
- `guess` holds its last value in IDLE and DONE.
- A consistent comparator needs at most WIDTH+1 probes. No search can exceed WIDTH+1 probes.

## Timing
- Reset values: all outputs are 0, state is IDLE, lo=0, hi=0. Reset asserted mid-search aborts within the same edge, and no `done` pulse is issued.
- The comparator is combinational. The cmp inputs are valid in the same cycle as the `guess` that produced them.
- `start` sampled at edge N: `guess` is valid and busy=1 from cycle N+1.
- A search of k probes: busy is high for cycles N+1 to N+k, and done=1 in cycle N+k+1.
- found, result and probes are stable from the `done` cycle onward.
- Back-to-back searches: the earliest accepted next `start` is in the cycle after `done`.

## Configuration
- `SAR_SEARCH_ERR_EN` defined:
  - In PROBE, a cmp code with more than one input high, or none high, is an error.
  - On error: err=1, found=0, result=guess, go to DONE.
  - err clears on the next accepted `start` or on reset.
- Undefined:
  - `err` is tied to 0.
  - Invalid codes are resolved by the eq > gt > lt priority; an all-zero code is treated as lt.

## Test plan
- Target 11 with a model comparator, WIDTH=4: guess sequence 7, 11 -> found=1, result=11, probes=2, done at start+3.
- Target 0: guesses 7, 3, 1, 0 -> found=1, result=0, probes=4.
- Target 15: guesses 7, 11, 13, 14, 15 -> found=1, result=15, probes=5 (the maximum).
- Comparator stuck at lt: guesses 7, 3, 1, 0, then lt at guess==lo -> found=0, result=0, probes=4, one `done` pulse.
- With the macro, cmp_gt=cmp_lt=1 on the first probe -> err=1, found=0, result=7, probes=1. Without the macro, the same stimulus is taken as gt and the next guess is 11.
- `start` re-pulsed while busy is ignored. `rst` asserted during the 2nd probe -> next cycle all outputs are 0, state is IDLE, and a fresh start behaves as in the first scenario.
